// File: rtl/filter_buffer_server_pkg.sv
// Shared constants and bank-state encoding for the filter-buffer server.
package filter_buffer_server_pkg;

  localparam int unsigned FILTER_DW         = 72;
  localparam int unsigned FILTER_BUF_AW     = 8;
  localparam int unsigned FILTER_BUF_DEPTH  = 256;
  localparam int unsigned NB_FILTER         = 4;
  localparam int unsigned FILTER_BUFFER_CNT = 2;
  localparam int unsigned BEAT_W            = FILTER_BUF_AW + 3;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_SERVING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/filter_buffer_server_sram.sv
// 1W1R synchronous RAM for one lane of one bank; read data registered and held.
module filter_bank_sram #(
  parameter int unsigned DW    = 72,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port: storage is not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: one-cycle latency, output holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/filter_buffer_server.sv
// Ping-pong filter buffer: loader fills one bank while the PE reads the other.
module filter_buffer_server
  import filter_buffer_server_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_ld_start,
  input  logic [FILTER_BUF_AW:0]   i_ld_words,
  input  logic                     i_wr_vld,
  output logic                     o_wr_rdy,
  input  logic [1:0]               i_wr_lane,
  input  logic [FILTER_BUF_AW-1:0] i_wr_addr,
  input  logic [FILTER_DW-1:0]     i_wr_data,
  input  logic                     i_tile_release,
  output logic                     o_fb_req_possible,
  input  logic                     i_fb_req,
  input  logic [FILTER_BUF_AW-1:0] i_fb_addr,
  output logic [FILTER_DW-1:0]     o_fb_data0,
  output logic [FILTER_DW-1:0]     o_fb_data1,
  output logic [FILTER_DW-1:0]     o_fb_data2,
  output logic [FILTER_DW-1:0]     o_fb_data3,
  output logic                     o_fb_data_vld,
  output logic [1:0]               o_err
);

  bank_state_t              state_q   [FILTER_BUFFER_CNT];
  bank_state_t              state_nxt [FILTER_BUFFER_CNT];
  logic [FILTER_BUF_AW:0]   words_q   [FILTER_BUFFER_CNT];
  logic [FILTER_BUF_AW:0]   words_nxt [FILTER_BUFFER_CNT];
  logic                     fill_sel_q, fill_sel_nxt;
  logic                     serve_sel_q, serve_sel_nxt;
  logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_nxt, beat_inc, beat_target;
  logic [1:0]               err_nxt;
  logic                     wr_fire;
  logic                     any_serving;
  logic                     rd_sel_q;
  logic [FILTER_DW-1:0]     rd_data [FILTER_BUFFER_CNT][NB_FILTER];

  assign o_wr_rdy    = (state_q[fill_sel_q] == BANK_FILLING);
  assign wr_fire     = i_wr_vld && o_wr_rdy;
  assign beat_inc    = beat_cnt_q + BEAT_W'(1);
  assign beat_target = {words_q[fill_sel_q], 2'b00};
  assign any_serving = (state_q[0] == BANK_SERVING) || (state_q[1] == BANK_SERVING);

  // Bank FSMs, fill/serve pointers, beat counter and sticky error flags.
  // Fill and release touch different banks, so both may apply in one cycle.
  always_comb begin
    for (int unsigned b = 0; b < FILTER_BUFFER_CNT; b++) begin
      state_nxt[b] = state_q[b];
      words_nxt[b] = words_q[b];
    end
    fill_sel_nxt  = fill_sel_q;
    serve_sel_nxt = serve_sel_q;
    beat_cnt_nxt  = beat_cnt_q;
    err_nxt       = o_err;

    if (i_ld_start) begin
      if (state_q[fill_sel_q] == BANK_EMPTY) begin
        state_nxt[fill_sel_q] = BANK_FILLING;
        words_nxt[fill_sel_q] = i_ld_words;
        beat_cnt_nxt          = '0;
      end else begin
        err_nxt[1] = 1'b1;
      end
    end

    if (i_wr_vld && !o_wr_rdy) err_nxt[1] = 1'b1;

    if (wr_fire) begin
      if ({1'b0, i_wr_addr} >= words_q[fill_sel_q]) err_nxt[1] = 1'b1;
      if (beat_inc == beat_target) begin
        state_nxt[fill_sel_q] = BANK_FULL;
        fill_sel_nxt          = ~fill_sel_q;
        beat_cnt_nxt          = '0;
      end else begin
        beat_cnt_nxt = beat_inc;
      end
    end

    if (i_tile_release && state_q[serve_sel_q] == BANK_SERVING) begin
      state_nxt[serve_sel_q] = BANK_EMPTY;
      serve_sel_nxt          = ~serve_sel_q;
    end else if (state_q[serve_sel_q] == BANK_FULL && !any_serving) begin
      state_nxt[serve_sel_q] = BANK_SERVING;
    end

    if (i_fb_req && (!o_fb_req_possible || {1'b0, i_fb_addr} >= words_q[serve_sel_q]))
      err_nxt[0] = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < FILTER_BUFFER_CNT; b++) begin
        state_q[b] <= BANK_EMPTY;
        words_q[b] <= '0;
      end
      fill_sel_q  <= 1'b0;
      serve_sel_q <= 1'b0;
      beat_cnt_q  <= '0;
      o_err       <= '0;
    end else begin
      for (int unsigned b = 0; b < FILTER_BUFFER_CNT; b++) begin
        state_q[b] <= state_nxt[b];
        words_q[b] <= words_nxt[b];
      end
      fill_sel_q  <= fill_sel_nxt;
      serve_sel_q <= serve_sel_nxt;
      beat_cnt_q  <= beat_cnt_nxt;
      o_err       <= err_nxt;
    end
  end

  // Read-side registers; rd_sel_q remembers which bank answered the last req
  // so the output mux stays stable even after serve_sel moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_fb_req_possible <= 1'b0;
      o_fb_data_vld     <= 1'b0;
      rd_sel_q          <= 1'b0;
    end else begin
      o_fb_req_possible <= (state_q[serve_sel_q] == BANK_SERVING);
      o_fb_data_vld     <= i_fb_req;
      if (i_fb_req) rd_sel_q <= serve_sel_q;
    end
  end

  for (genvar b = 0; b < FILTER_BUFFER_CNT; b++) begin : g_bank
    for (genvar l = 0; l < NB_FILTER; l++) begin : g_lane
      filter_bank_sram #(
        .DW    (FILTER_DW),
        .AW    (FILTER_BUF_AW),
        .DEPTH (FILTER_BUF_DEPTH)
      ) u_sram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire && (fill_sel_q == 1'(b)) && (i_wr_lane == 2'(l))),
        .waddr (i_wr_addr),
        .wdata (i_wr_data),
        .re    (i_fb_req && (serve_sel_q == 1'(b))),
        .raddr (i_fb_addr),
        .rdata (rd_data[b][l])
      );
    end
  end

  assign o_fb_data0 = rd_data[rd_sel_q][0];
  assign o_fb_data1 = rd_data[rd_sel_q][1];
  assign o_fb_data2 = rd_data[rd_sel_q][2];
  assign o_fb_data3 = rd_data[rd_sel_q][3];

endmodule

// File: tb/tb_filter_buffer_server.sv
// Self-checking bench for filter_buffer_server.
module tb_filter_buffer_server;
  import filter_buffer_server_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     ld_start;
  logic [FILTER_BUF_AW:0]   ld_words;
  logic                     wr_vld;
  logic                     wr_rdy;
  logic [1:0]               wr_lane;
  logic [FILTER_BUF_AW-1:0] wr_addr;
  logic [FILTER_DW-1:0]     wr_data;
  logic                     tile_release;
  logic                     fb_req_possible;
  logic                     fb_req;
  logic [FILTER_BUF_AW-1:0] fb_addr;
  logic [FILTER_DW-1:0]     fb_data0, fb_data1, fb_data2, fb_data3;
  logic                     fb_data_vld;
  logic [1:0]               err;

  int unsigned total  = 0;
  int unsigned passed = 0;

  typedef struct packed {
    logic [3:0][FILTER_DW-1:0] d;
    logic                      chk;
  } sb_t;
  sb_t sb [$];

  typedef struct {
    int unsigned addr;
    int unsigned tag;
    bit          chk;
    logic [1:0]  exp_err;
  } rd_vec_t;
  rd_vec_t tbl [28];

  filter_buffer_server dut (
    .clk               (clk),
    .rst               (rst),
    .i_ld_start        (ld_start),
    .i_ld_words        (ld_words),
    .i_wr_vld          (wr_vld),
    .o_wr_rdy          (wr_rdy),
    .i_wr_lane         (wr_lane),
    .i_wr_addr         (wr_addr),
    .i_wr_data         (wr_data),
    .i_tile_release    (tile_release),
    .o_fb_req_possible (fb_req_possible),
    .i_fb_req          (fb_req),
    .i_fb_addr         (fb_addr),
    .o_fb_data0        (fb_data0),
    .o_fb_data1        (fb_data1),
    .o_fb_data2        (fb_data2),
    .o_fb_data3        (fb_data3),
    .o_fb_data_vld     (fb_data_vld),
    .o_err             (err)
  );

  always #5 clk = ~clk;

  function automatic logic [FILTER_DW-1:0] pat(int unsigned tag, int unsigned lane, int unsigned addr);
    return {8'(tag), 8'(lane), 8'(addr), 24'h5A5A5A, 8'(addr), 8'(lane), 8'(tag)};
  endfunction

  task automatic check(string name, logic [FILTER_DW-1:0] act, logic [FILTER_DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one cycle; verify the read pipeline against the scoreboard.
  task automatic tick();
    logic req_was;
    logic [3:0][FILTER_DW-1:0] got;
    sb_t e;
    req_was = fb_req;
    @(posedge clk);
    #1;
    check("data_vld", 72'(fb_data_vld), 72'(req_was));
    if (req_was) begin
      if (sb.size() == 0) begin
        check("sb_empty", 72'(1), 72'(0));
      end else begin
        e = sb.pop_front();
        got = {fb_data3, fb_data2, fb_data1, fb_data0};
        if (e.chk)
          for (int l = 0; l < 4; l++) check($sformatf("rd_data%0d", l), got[l], e.d[l]);
      end
    end
  endtask

  task automatic do_req(int unsigned addr, int unsigned tag, bit chk);
    sb_t e;
    for (int l = 0; l < 4; l++) e.d[l] = pat(tag, l, addr);
    e.chk = chk;
    sb.push_back(e);
    fb_req  = 1'b1;
    fb_addr = 8'(addr);
  endtask

  task automatic ld(int unsigned words);
    ld_start = 1'b1;
    ld_words = 9'(words);
    tick();
    ld_start = 1'b0;
  endtask

  // Write nbeats beats (addr-major, lane-minor); optional release on last beat
  // and optional concurrent reads of the serving bank.
  task automatic fill(int unsigned words, int unsigned tag, int unsigned nbeats,
                      bit rel_last, bit rd, int unsigned rd_tag);
    int unsigned k = 0;
    for (int unsigned a = 0; a < words; a++) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (k < nbeats) begin
          check("wr_rdy_beat", 72'(wr_rdy), 72'(1));
          wr_vld  = 1'b1;
          wr_lane = 2'(l);
          wr_addr = 8'(a);
          wr_data = pat(tag, l, a);
          tile_release = (rel_last && k == nbeats - 1);
          if (rd) do_req(k % 8, rd_tag, 1'b1);
          tick();
          k++;
        end
      end
    end
    wr_vld = 1'b0;
    tile_release = 1'b0;
    fb_req = 1'b0;
  endtask

  task automatic run_table(int unsigned first, int unsigned count);
    for (int unsigned i = first; i < first + count; i++) begin
      do_req(tbl[i].addr, tbl[i].tag, tbl[i].chk);
      tick();
      check($sformatf("tbl%0d_err", i), 72'(err), 72'(tbl[i].exp_err));
    end
    fb_req = 1'b0;
    tick();
  endtask

  task automatic wait_possible(int unsigned max_cyc);
    int unsigned n = 0;
    while (!fb_req_possible && n < max_cyc) begin
      tick();
      n++;
    end
    check("possible_wait", 72'(fb_req_possible), 72'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Read vectors: {addr, tag, check data, err after the req edge}.
    for (int unsigned i = 0; i < 8; i++) tbl[i] = '{i, 0, 1'b1, 2'b00};
    tbl[8]  = '{3, 0, 1'b1, 2'b00};
    tbl[9]  = '{7, 0, 1'b1, 2'b00};
    tbl[10] = '{0, 0, 1'b1, 2'b00};
    for (int unsigned i = 0; i < 4; i++) tbl[11+i] = '{i, 1, 1'b1, 2'b00};
    for (int unsigned i = 0; i < 8; i++) tbl[15+i] = '{i, 2, 1'b1, 2'b00};
    tbl[23] = '{8, 2, 1'b0, 2'b01};
    tbl[24] = '{0, 5, 1'b1, 2'b00};
    tbl[25] = '{5, 5, 1'b1, 2'b00};
    tbl[26] = '{7, 5, 1'b1, 2'b00};
    tbl[27] = '{2, 5, 1'b1, 2'b00};

    rst = 1'b1; ld_start = 0; ld_words = '0; wr_vld = 0; wr_lane = '0;
    wr_addr = '0; wr_data = '0; tile_release = 0; fb_req = 0; fb_addr = '0;
    tick();
    tick();
    check("rst_rdy",      72'(wr_rdy), 72'(0));
    check("rst_possible", 72'(fb_req_possible), 72'(0));
    check("rst_err",      72'(err), 72'(0));
    check("rst_data0",    fb_data0, 72'(0));
    rst = 1'b0;
    tick();

    // Error flags: read while not possible, then write while not ready.
    do_req(0, 0, 1'b0);
    tick();
    check("err_rd_not_possible", 72'(err), 72'(2'b01));
    fb_req = 1'b0;
    wr_vld = 1'b1;
    tick();
    check("err_wr_not_rdy", 72'(err), 72'(2'b11));
    wr_vld = 1'b0;
    rst = 1'b1;
    tick();
    check("err_cleared", 72'(err), 72'(0));
    rst = 1'b0;
    tick();

    // Test 1: fill bank0, 8 words x 4 lanes.
    ld(8);
    check("rdy_after_ld", 72'(wr_rdy), 72'(1));
    fill(8, 0, 32, 1'b0, 1'b0, 0);
    check("rdy_after_last", 72'(wr_rdy), 72'(0));
    check("possible_e0", 72'(fb_req_possible), 72'(0));
    tick();
    check("possible_e1", 72'(fb_req_possible), 72'(0));
    tick();
    check("possible_e2", 72'(fb_req_possible), 72'(1));

    // Test 2: back-to-back reads of bank0.
    run_table(0, 11);

    // Test 3: fill bank1 while reading bank0, then release bank0.
    ld(4);
    fill(4, 1, 16, 1'b0, 1'b1, 0);
    tick();
    check("possible_hold", 72'(fb_req_possible), 72'(1));
    tile_release = 1'b1;
    tick();
    tile_release = 1'b0;
    check("rel_r0", 72'(fb_req_possible), 72'(1));
    tick();
    check("rel_r1", 72'(fb_req_possible), 72'(0));
    tick();
    check("rel_r2", 72'(fb_req_possible), 72'(1));
    run_table(11, 4);

    // Test 4: last beat of bank0 coincides with release of bank1.
    ld(8);
    fill(8, 2, 32, 1'b1, 1'b0, 0);
    check("sim_r0", 72'(fb_req_possible), 72'(1));
    tick();
    check("sim_r1", 72'(fb_req_possible), 72'(0));
    tick();
    check("sim_r2", 72'(fb_req_possible), 72'(1));
    check("err_none", 72'(err), 72'(0));
    // Test 5 (part): addr == words sets err[0].
    run_table(15, 9);
    ld(2);
    check("bank1_ld_ok", 72'(wr_rdy), 72'(1));
    check("err_after_ld", 72'(err), 72'(2'b01));
    fill(2, 3, 1, 1'b0, 1'b0, 0);
    ld(2);
    check("err_ld_busy", 72'(err), 72'(2'b11));

    // Test 6: reset in the middle of a fill, then a clean refill.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ld(8);
    fill(8, 4, 13, 1'b0, 1'b0, 0);
    rst = 1'b1;
    tick();
    check("midrst_rdy",      72'(wr_rdy), 72'(0));
    check("midrst_possible", 72'(fb_req_possible), 72'(0));
    check("midrst_err",      72'(err), 72'(0));
    rst = 1'b0;
    tick();
    ld(8);
    fill(8, 5, 32, 1'b0, 1'b0, 0);
    wait_possible(8);
    run_table(24, 4);
    check("data_hold", fb_data0, pat(5, 0, 2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
